// File: rtl/test_status_pkg.sv
// Shared definitions for the end-of-test status monitor: FSM state encoding
// and the register values that mean "done" and "passed".
package test_status_pkg;

  typedef enum logic [2:0] {
    TSM_IDLE    = 3'd0,
    TSM_RUN     = 3'd1,
    TSM_PASS    = 3'd2,
    TSM_FAIL    = 3'd3,
    TSM_TIMEOUT = 3'd4
  } tsm_state_e;

  // Value a core writes to its done register once it has finished.
  localparam int unsigned TSM_DONE_VAL = 1;
  // Value a core writes to its result register when its test passed.
  localparam int unsigned TSM_PASS_VAL = 1;

endpackage

// File: rtl/tsm_chan_latch.sv
// Per-channel debounce and verdict latch. A channel must see its done
// register equal to TSM_DONE_VAL for STABLE_CYCLES consecutive enabled
// cycles; on the cycle the count is reached the result register is sampled
// and the done/fail pair is frozen until the next clear.
module tsm_chan_latch
  import test_status_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] done,
  input  logic [DATA_W-1:0] result,
  output logic              chan_done,
  output logic              chan_fail,
  output logic              done_next
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW:0] STABLE_LIM = (CW+1)'(STABLE_CYCLES);

  logic [CW-1:0] stab_cnt;
  logic [CW:0]   cnt_inc;
  logic          done_match;
  logic          latch_now;

  assign done_match = (done == DATA_W'(TSM_DONE_VAL));
  assign cnt_inc    = {1'b0, stab_cnt} + (CW+1)'(1);
  assign latch_now  = enable && !chan_done && done_match && (cnt_inc >= STABLE_LIM);
  // Lets the top see a channel that latches on the coming edge.
  assign done_next  = chan_done | latch_now;

  // Stability counter plus done/fail latch; frozen once the channel latched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stab_cnt  <= '0;
      chan_done <= 1'b0;
      chan_fail <= 1'b0;
    end else if (clear) begin
      stab_cnt  <= '0;
      chan_done <= 1'b0;
      chan_fail <= 1'b0;
    end else if (enable && !chan_done) begin
      if (done_match) begin
        stab_cnt <= (cnt_inc >= STABLE_LIM) ? STABLE_LIM[CW-1:0] : cnt_inc[CW-1:0];
      end else begin
        stab_cnt <= '0;
      end
      if (latch_now) begin
        chan_done <= 1'b1;
        chan_fail <= (result != DATA_W'(TSM_PASS_VAL));
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// End-of-test monitor: arms on start_i, waits for every channel to latch a
// debounced done, then reports a sticky PASS/FAIL verdict and the number of
// cycles spent running. Define TEST_STATUS_MONITOR_TIMEOUT_EN to build the
// run-cycle limit and the TIMEOUT verdict; otherwise timeout_o is tied low
// and the run lasts until all channels latch.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CHANNELS       = 1,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [CHANNELS*DATA_W-1:0] done_i,
  input  logic [CHANNELS*DATA_W-1:0] result_i,
  output logic                       busy_o,
  output logic                       finished_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [CHANNELS-1:0]        chan_done_o,
  output logic [CHANNELS-1:0]        chan_fail_o,
  output logic [CNT_W-1:0]           cycle_cnt_o
);

  tsm_state_e state, next_state;

  logic [CHANNELS-1:0] done_next;
  logic                start_clear;
  logic                run_en;
  logic                all_done;
  logic                all_done_next;
  logic                any_fail;
  logic                expired;

  // A start is honoured everywhere except RUN and wipes the previous run.
  assign start_clear   = start_i && (state != TSM_RUN);
  assign run_en        = (state == TSM_RUN);
  assign all_done      = &chan_done_o;
  assign all_done_next = &done_next;
  assign any_fail      = |chan_fail_o;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tsm_chan_latch #(
      .DATA_W        (DATA_W),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_latch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear     (start_clear),
      .enable    (run_en),
      .done      (done_i[c*DATA_W +: DATA_W]),
      .result    (result_i[c*DATA_W +: DATA_W]),
      .chan_done (chan_done_o[c]),
      .chan_fail (chan_fail_o[c]),
      .done_next (done_next[c])
    );
  end

`ifdef TEST_STATUS_MONITOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  // A channel set completing on the expiry edge still earns its verdict.
  assign expired = (cycle_cnt_o == LIMIT) && !all_done_next;
`else
  assign expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= TSM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the verdict waits for every channel, no early exit.
  always_comb begin
    next_state = state;
    unique case (state)
      TSM_IDLE: begin
        if (start_i) next_state = TSM_RUN;
      end
      TSM_RUN: begin
        if (all_done) begin
          next_state = any_fail ? TSM_FAIL : TSM_PASS;
        end else if (expired) begin
          next_state = TSM_TIMEOUT;
        end
      end
      TSM_PASS, TSM_FAIL, TSM_TIMEOUT: begin
        if (start_i) next_state = TSM_RUN;
      end
      default: next_state = TSM_IDLE;
    endcase
  end

  // Run-cycle counter: counts while RUN continues, saturates, holds after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_o <= '0;
    end else if (start_clear) begin
      cycle_cnt_o <= '0;
    end else if (run_en && (next_state == TSM_RUN) && (cycle_cnt_o != '1)) begin
      cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
    end
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy_o    = (state == TSM_RUN);
    pass_o    = (state == TSM_PASS);
    fail_o    = (state == TSM_FAIL);
`ifdef TEST_STATUS_MONITOR_TIMEOUT_EN
    timeout_o = (state == TSM_TIMEOUT);
`else
    timeout_o = 1'b0;
`endif
    finished_o = pass_o | fail_o | timeout_o;
  end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Parametrised end-of-test monitor for the tinyriscv simulation top. It watches a per-channel "done" register and "result" register for each of `CHANNELS` cores or harts, debounces them, and latches a per-channel verdict. It then reports one overall PASS / FAIL / TIMEOUT status and a cycle count, which the bench uses to print the banner and call `$finish`.

## Interface
- `DATA_W`, 32, width of the monitored done/result registers.
- `CHANNELS`, 1, number of independent done/result pairs.
- `STABLE_CYCLES`, 2, consecutive cycles `done == 1` must hold before the channel latches (≥1).
- `TIMEOUT_CYCLES`, 1000000, run-cycle limit before TIMEOUT (≥1; used only with timeout compiled in).
- `CNT_W`, 32, width of the cycle counter.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  single-cycle pulse; arms the monitor.
- `done_i`  in  CHANNELS×DATA_W  per-channel done register (x26 equivalent).
- `result_i`  in  CHANNELS×DATA_W  per-channel result register (x27 equivalent).
- `busy_o`  out  1  monitor is in RUN.
- `finished_o`  out  1  sticky; test has reached a verdict.
- `pass_o`  out  1  sticky; all channels done with `result == 1`.
- `fail_o`  out  1  sticky; at least one channel done with `result != 1`.
- `timeout_o`  out  1  sticky; the limit expired before all channels were done.
- `chan_done_o`  out  CHANNELS  per-channel latched done.
- `chan_fail_o`  out  CHANNELS  per-channel latched fail.
- `cycle_cnt_o`  out  CNT_W  number of cycles spent in RUN.

## Operation
- **FSM states:** IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal. Only reset or a new `start_i` leaves a terminal state.
- **IDLE → RUN** on `start_i`. On that edge, clear `cycle_cnt_o`, all stability counters, `chan_done_o` and `chan_fail_o`.
- **Terminal → RUN** on `start_i`. Same clears, plus clear all sticky verdict flags.
- **`start_i` while in RUN:** ignored.
- **Channel latch:** a channel sees `done_i[c] == 1` (full-width compare). Its stability counter then increments each cycle. If `done_i[c] != 1` for a cycle, the counter resets to 0. The counter saturates at `STABLE_CYCLES`. When it reaches `STABLE_CYCLES`, the channel sets `chan_done_o[c]` and captures `chan_fail_o[c] = (result_i[c] != 1)`, both sampled in that same cycle. Latched channels ignore further input changes.
- **Verdict, RUN → PASS/FAIL:** evaluated in the cycle after the last channel latches, once every channel has latched. The FSM goes to FAIL if any `chan_fail_o` bit is set, otherwise to PASS. Early exit on the first failing channel is not allowed; all channels must report.
- **Cycle counter:** increments every cycle in RUN and saturates at all-ones. It holds its value in terminal states.
- **Timeout:** the run-cycle limit expires when `cycle_cnt_o == TIMEOUT_CYCLES - 1` and not all channels are latched. The FSM then goes RUN → TIMEOUT. `chan_done_o` and `chan_fail_o` keep their partial values for debug.
- **Simultaneous events:** if the last channel latches in the same cycle the limit expires, the verdict wins (PASS/FAIL, not TIMEOUT).
- **Reset mid-run:** returns to IDLE and clears everything.

## Timing
- **Reset values:** every output is 0 and the FSM is in IDLE.
- `busy_o` is 1 from the cycle after `start_i` until the cycle the FSM enters a terminal state.
- **Latch latency:** with `done_i` and `result_i` stable from cycle t, `chan_done_o` rises at t+`STABLE_CYCLES`.
- **Verdict latency:** `finished_o` and `pass_o`/`fail_o` rise one cycle after the last `chan_done_o` bit.
- `finished_o` is always exactly one of {`pass_o`, `fail_o`, `timeout_o`} ORed; the three flags are mutually exclusive.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **Macro:** `TEST_STATUS_MONITOR_TIMEOUT_EN`.
- **Defined:** the timeout comparator is built, and TIMEOUT is reachable as described above.
- **Undefined:**
  - The comparator is not built, the TIMEOUT transition is absent, and `timeout_o` is tied to 0.
  - RUN lasts until all channels latch.
  - `cycle_cnt_o` still counts and saturates.

## Structure
- **Shared package `test_status_pkg`:**
  - the FSM state enum `tsm_state_e` (IDLE/RUN/PASS/FAIL/TIMEOUT);
  - the constant `TSM_DONE_VAL = 1`;
  - the constant `TSM_PASS_VAL = 1`.
- **Sub-module `tsm_chan_latch`:** one per channel via a generate loop. It holds the stability counter, the compare against `TSM_DONE_VAL`, and the done/fail latch, and takes a clear input driven from the FSM.
- **Top level:** the FSM, the cycle counter, the timeout compare, and the all/any reduction across channels.

## Test plan
- **Single-channel pass** (`CHANNELS=1`, `STABLE_CYCLES=2`): `start_i` at t0, then `done_i=1` and `result_i=1` from t10 → `chan_done_o` rises at t12, `pass_o` and `finished_o` at t13, `busy_o` falls at t13.
- **Glitch rejection:** `done_i=1` for 1 cycle, back to 0, then 1 from t20 → no latch on the glitch; latch at t22.
- **Multi-channel fail** (`CHANNELS=4`): channels 0–3 finish at staggered cycles, with channel 2 `result_i=3` → `chan_fail_o=4'b0100`, and `fail_o` rises one cycle after the last channel latches.
- **Timeout** (macro defined, `TIMEOUT_CYCLES=50`): channel 1 never done → `timeout_o` at the 50th RUN cycle, `cycle_cnt_o=49`, `chan_done_o` shows the partial values. The same stimulus without the macro → still busy at cycle 200, `timeout_o=0`.
- **Simultaneous latch/timeout** (`TIMEOUT_CYCLES=12`): the last channel latches exactly in the expiry cycle → `pass_o=1`, `timeout_o=0`.
- **Restart and reset:** `start_i` in PASS clears all flags and re-enters RUN. Asserting `rst_ni` low mid-RUN → all outputs 0 asynchronously, FSM in IDLE.
